mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_arb_rr_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding and master indices.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic logic [1:0] idx_onehot(input logic idx);
        return (idx == M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr_pick.sv
// Two-way winner selection: round-robin by default, fixed m0 priority when
// MEM_ARBITER_FIXED_PRIO_EN is defined.
module arb_rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    // With no request the pick is a don't-care; reuse last to keep it stable.
    assign winner = req[0] ? M0 : (req[1] ? M1 : last);
`else
    always_comb begin
        case (req)
            2'b01:   winner = M0;
            2'b10:   winner = M1;
            default: winner = (last == M0) ? M1 : M0;
        endcase
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two masters onto one single-port RAM; a write takes 2 cycles, a read 3.
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wmask,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic                mem_rstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    state_t              state;
    logic                cur_idx;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [MASK_W-1:0]   cur_wmask;
    logic [1:0]          gnt_q;
    logic [1:0]          rvalid_q;
    logic [MASK_W-1:0]   mem_wmask_q;
    logic                mem_rstrb_q;
    logic                last;
    logic                winner;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [MASK_W-1:0]   sel_wmask;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    assign last = M1;
`endif

    arb_rr_pick u_pick (
        .req    ({m1_req, m0_req}),
        .last   (last),
        .winner (winner)
    );

    // NOTE: every output of always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_wmask = m0_wmask;
        if (winner == M1) begin
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_wmask = m1_wmask;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            cur_idx     <= M0;
            cur_addr    <= '0;
            cur_wdata   <= '0;
            cur_wmask   <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            mem_wmask_q <= '0;
            mem_rstrb_q <= 1'b0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last        <= M1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        cur_idx     <= winner;
                        cur_addr    <= sel_addr;
                        cur_wdata   <= sel_wdata;
                        cur_wmask   <= sel_wmask;
                        gnt_q       <= idx_onehot(winner);
                        mem_wmask_q <= sel_wmask;
                        mem_rstrb_q <= (sel_wmask == '0);
`ifndef MEM_ARBITER_FIXED_PRIO_EN
                        last        <= winner;
`endif
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt_q       <= '0;
                    mem_wmask_q <= '0;
                    mem_rstrb_q <= 1'b0;
                    if (cur_wmask == '0) begin
                        rvalid_q <= idx_onehot(cur_idx);
                        state    <= RDATA;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RDATA: begin
                    rvalid_q <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];

    // RAM read data is already registered, so it is forwarded straight to the winner.
    assign m0_rdata  = rvalid_q[0] ? mem_rdata : '0;
    assign m1_rdata  = rvalid_q[1] ? mem_rdata : '0;

    assign mem_addr  = cur_addr;
    assign mem_wdata = cur_wdata;
    assign mem_wmask = mem_wmask_q;
    assign mem_rstrb = mem_rstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed traffic with hand-computed grant/rvalid timing,
// backed by a small byte-maskable RAM model with registered read data.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wmask  (m0_wmask),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wmask  (m1_wmask),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ram [0:63] = '{default: '0};

    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    typedef struct {
        bit          is_rv;
        bit          m;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_gnt(bit m, int c, logic [31:0] addr, logic [31:0] wdata,
                                     logic [3:0] mask);
        exp_q.push_back('{is_rv: 1'b0, m: m, cyc: c, addr: addr, data: wdata, mask: mask});
    endfunction

    function automatic void push_rv(bit m, int c, logic [31:0] rdata);
        exp_q.push_back('{is_rv: 1'b1, m: m, cyc: c, addr: '0, data: rdata, mask: '0});
    endfunction

    // Uncontended request raised just after edge b: gnt seen in cycle b+1, rvalid in b+2.
    function automatic void push_solo(bit m, int b, logic [31:0] addr, logic [31:0] wdata,
                                      logic [3:0] mask, logic [31:0] rdata);
        push_gnt(m, b + 1, addr, wdata, mask);
        if (mask == 4'h0) push_rv(m, b + 2, rdata);
    endfunction

    exp_t mon_e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (m0_gnt || m1_gnt) begin
                check("gnt_onehot", 32'(m0_gnt & m1_gnt), 32'd0);
                if (exp_q.size() == 0) begin
                    check("gnt_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("gnt_kind", 32'(mon_e.is_rv), 32'd0);
                    check("gnt_master", 32'(m1_gnt), 32'(mon_e.m));
                    check("gnt_cycle", cyc, mon_e.cyc);
                    check("mem_addr", mem_addr, mon_e.addr);
                    check("mem_wdata", mem_wdata, mon_e.data);
                    check("mem_wmask", 32'(mem_wmask), 32'(mon_e.mask));
                    check("mem_rstrb", 32'(mem_rstrb), 32'(mon_e.mask == 4'h0));
                end
            end else begin
                check("idle_wmask", 32'(mem_wmask), 32'd0);
                check("idle_rstrb", 32'(mem_rstrb), 32'd0);
            end
            if (m0_rvalid || m1_rvalid) begin
                check("rv_onehot", 32'(m0_rvalid & m1_rvalid), 32'd0);
                if (exp_q.size() == 0) begin
                    check("rv_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rv_kind", 32'(mon_e.is_rv), 32'd1);
                    check("rv_master", 32'(m1_rvalid), 32'(mon_e.m));
                    check("rv_cycle", cyc, mon_e.cyc);
                    check("rv_rdata", m1_rvalid ? m1_rdata : m0_rdata, mon_e.data);
                    check("rv_other_rdata", m1_rvalid ? m0_rdata : m1_rdata, 32'd0);
                end
            end else begin
                check("idle_rdata", m0_rdata | m1_rdata, 32'd0);
            end
        end
    end

    task automatic start(output int b);
        @(posedge clk);
        #1;
        b = cyc;
    endtask

    // Raise req (caller is just after an edge), hold it until gnt, drop it the cycle after.
    task automatic issue(input bit m, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask);
        bit got;
        got = 1'b0;
        if (m) begin
            m1_req = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wmask = wmask;
        end else begin
            m0_req = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wmask = wmask;
        end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = m ? m1_gnt : m0_gnt;
        end
        check(m ? "m1_gnt_seen" : "m0_gnt_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (m) begin
            m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
        end else begin
            m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
        end
    endtask

    bit order [0:3];
    int b;

    initial begin
        resetn = 1'b0;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

        // Full write then read-back by m0.
        start(b);
        push_solo(1'b0, b, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
        issue(1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
        start(b);
        push_solo(1'b0, b, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
        issue(1'b0, 32'h10, 32'h0, 4'h0);

        // m1 full write, byte-2 write, read-back shows only byte 2 changed.
        start(b);
        push_solo(1'b1, b, 32'h20, 32'h11223344, 4'hF, 32'h0);
        issue(1'b1, 32'h20, 32'h11223344, 4'hF);
        start(b);
        push_solo(1'b1, b, 32'h20, 32'h00AB0000, 4'h4, 32'h0);
        issue(1'b1, 32'h20, 32'h00AB0000, 4'h4);
        start(b);
        push_solo(1'b1, b, 32'h20, 32'h0, 4'h0, 32'h11AB3344);
        issue(1'b1, 32'h20, 32'h0, 4'h0);

        // Contention: each master reads twice, re-raising req one cycle after dropping it.
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        order = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        start(b);
        for (int k = 0; k < 4; k++) begin
            push_gnt(order[k], b + 1 + 3 * k, order[k] ? 32'h20 : 32'h10, 32'h0, 4'h0);
            push_rv(order[k], b + 2 + 3 * k, order[k] ? 32'h11AB3344 : 32'hDEADBEEF);
        end
        fork
            begin
                issue(1'b0, 32'h10, 32'h0, 4'h0);
                @(posedge clk); #1;
                issue(1'b0, 32'h10, 32'h0, 4'h0);
            end
            begin
                issue(1'b1, 32'h20, 32'h0, 4'h0);
                @(posedge clk); #1;
                issue(1'b1, 32'h20, 32'h0, 4'h0);
            end
        join

        // Back-to-back: m1 write waits until m0's read has fully completed.
        start(b);
        push_gnt(1'b0, b + 1, 32'h10, 32'h0, 4'h0);
        push_rv(1'b0, b + 2, 32'hDEADBEEF);
        push_gnt(1'b1, b + 4, 32'h30, 32'hCAFEF00D, 4'hF);
        fork
            issue(1'b0, 32'h10, 32'h0, 4'h0);
            issue(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        join
        start(b);
        push_solo(1'b1, b, 32'h30, 32'h0, 4'h0, 32'hCAFEF00D);
        issue(1'b1, 32'h30, 32'h0, 4'h0);

        // Reset on the edge that would enter RDATA: the read is abandoned, no rvalid.
        start(b);
        push_gnt(1'b0, b + 1, 32'h10, 32'h0, 4'h0);
        fork
            issue(1'b0, 32'h10, 32'h0, 4'h0);
            begin
                @(posedge clk); #1;
                resetn = 1'b0;
                @(posedge clk); #1;
                resetn = 1'b1;
            end
        join
        @(negedge clk);
        check("rrst_mem_addr", mem_addr, 32'd0);
        check("rrst_mem_wdata", mem_wdata, 32'd0);
        check("rrst_outputs", {26'd0, mem_wmask, mem_rstrb, m1_gnt | m0_gnt | m1_rvalid | m0_rvalid},
              32'd0);

        // After reset, m0 wins a simultaneous request even though it was served last.
        start(b);
        push_gnt(1'b0, b + 1, 32'h10, 32'h0, 4'h0);
        push_rv(1'b0, b + 2, 32'hDEADBEEF);
        push_gnt(1'b1, b + 4, 32'h20, 32'h0, 4'h0);
        push_rv(1'b1, b + 5, 32'h11AB3344);
        fork
            issue(1'b0, 32'h10, 32'h0, 4'h0);
            issue(1'b1, 32'h20, 32'h0, 4'h0);
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
